// File: rtl/video_fetch_if.sv
// Memory read-burst port between the framebuffer prefetcher and SDRAM.
//   mem_req    : burst read request, held until mem_ack
//   mem_addr   : burst start word address, stable while mem_req=1
//   mem_ack    : one-cycle request-accepted strobe
//   mem_rvalid : read data beat valid (BURST beats per ack, may be gapped)
//   mem_rdata  : read data beat
interface video_fetch_if #(
  parameter int unsigned ADDR_W = 24
) ();
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/video_fetch.sv
// Framebuffer prefetch stage feeding a 16bpp video controller.
// Streams 32-bit words from SDRAM in bursts into a show-ahead FIFO and
// restarts at fb_base on every vsync rising edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   fb_base    : framebuffer word base, sampled at vsync rising edge
//   vsync      : vsync from the video controller (active high)
//   vid_req    : one-cycle pop strobe from the video controller
//   viddata    : FIFO head word, 0 when empty (combinational)
//   underflow  : sticky, vid_req seen while FIFO empty
//   mem        : memory burst read port (master side)
module video_fetch #(
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned BURST  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic              vsync,
  input  logic              vid_req,
  output logic [31:0]       viddata,
  output logic              underflow,
  video_fetch_if.master     mem
);
  localparam int unsigned FRAME_WORDS = H_RES * V_RES / 2;
  localparam int unsigned PTR_W       = $clog2(DEPTH);
  localparam int unsigned CNT_W       = $clog2(DEPTH + 1);
  localparam int unsigned BEAT_W      = $clog2(BURST + 1);
  localparam int unsigned FETCH_W     = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DRAIN} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_vsync_q, r_armed, r_mem_req, r_underflow;
  logic [ADDR_W-1:0]  r_addr, r_mem_addr;
  logic [FETCH_W-1:0] r_fetched;
  logic [BEAT_W-1:0]  r_beats;
  logic [CNT_W-1:0]   r_count;
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [31:0]        r_fifo [DEPTH];

  logic w_vs_rise, w_space_ok, w_issue, w_ack_take, w_beat, w_push, w_pop, w_last_beat;

  assign w_vs_rise   = vsync & ~r_vsync_q;
  // r_beats doubles as the outstanding-word count of the single in-flight burst
  assign w_space_ok  = (32'(r_count) + 32'(r_beats) + BURST) <= DEPTH;
  assign w_pop       = vid_req && (r_count != '0) && !w_vs_rise;
  assign w_last_beat = w_beat && (r_beats == BEAT_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_state_nxt = S_REQ;
      S_REQ: begin
        if (mem.mem_ack)    w_state_nxt = w_vs_rise ? S_DRAIN : S_DATA;
        else if (w_vs_rise) w_state_nxt = S_IDLE;
      end
      S_DATA: begin
        if (w_last_beat)    w_state_nxt = S_IDLE;
        else if (w_vs_rise) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (w_last_beat) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-state control strobes; beats arriving with vs_rise belong to the old frame
  always_comb begin
    w_issue    = 1'b0;
    w_ack_take = 1'b0;
    w_beat     = 1'b0;
    w_push     = 1'b0;
    case (r_state)
      S_IDLE:  w_issue = r_armed && (32'(r_fetched) < FRAME_WORDS) && w_space_ok && !w_vs_rise;
      S_REQ:   w_ack_take = mem.mem_ack && !w_vs_rise;
      S_DATA: begin
        w_beat = mem.mem_rvalid;
        w_push = mem.mem_rvalid && !w_vs_rise;
      end
      S_DRAIN: w_beat = mem.mem_rvalid;
      default: ;
    endcase
  end

  // Frame address/progress tracking and memory request outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_q   <= 1'b0;
      r_armed     <= 1'b0;
      r_addr      <= '0;
      r_fetched   <= '0;
      r_beats     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_vsync_q <= vsync;
      if (w_vs_rise) begin
        r_addr    <= fb_base;
        r_fetched <= '0;
        r_armed   <= 1'b1;
      end else if (w_ack_take) begin
        r_addr    <= r_addr + ADDR_W'(BURST);
        r_fetched <= r_fetched + FETCH_W'(BURST);
      end
      if (r_state == S_REQ && mem.mem_ack) r_beats <= BEAT_W'(BURST);
      else if (w_beat)                     r_beats <= r_beats - BEAT_W'(1);
      if (w_issue) begin
        r_mem_req  <= 1'b1;
        r_mem_addr <= r_addr;
      end else if (r_state == S_REQ && (mem.mem_ack || w_vs_rise)) begin
        r_mem_req  <= 1'b0;
      end
      if (w_vs_rise)                       r_underflow <= 1'b0;
      else if (vid_req && r_count == '0)   r_underflow <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; vs_rise flushes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_vs_rise) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // FIFO storage; contents are only visible through a non-zero count
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= mem.mem_rdata;
  end

  assign viddata      = (r_count != '0) ? r_fifo[r_rd_ptr] : 32'd0;
  assign underflow    = r_underflow;
  assign mem.mem_req  = r_mem_req;
  assign mem.mem_addr = r_mem_addr;
endmodule

// File: tb/tb_video_fetch.sv
module tb_video_fetch;
  localparam int unsigned H_RES  = 16;
  localparam int unsigned V_RES  = 2;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned BURST  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] fb_base = '0;
  logic              vsync = 1'b0;
  logic              vid_req = 1'b0;
  logic [31:0]       viddata;
  logic              underflow;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q [$];
  logic [31:0] req_log [$];
  int n_acked = 0;
  int ack_budget = 1000;
  int gap = 0;
  int beat_idx = 0;

  always #5 clk = ~clk;

  video_fetch_if #(.ADDR_W(ADDR_W)) mem ();

  video_fetch #(
    .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BURST(BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fb_base(fb_base), .vsync(vsync), .vid_req(vid_req),
    .viddata(viddata), .underflow(underflow), .mem(mem)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Compare head against scoreboard, then pulse one pop
  task automatic pop(input string tag);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check(tag, viddata, e);
    vid_req = 1'b1;
    step(1);
    vid_req = 1'b0;
    step(1);
  endtask

  task automatic vs_pulse(input logic [ADDR_W-1:0] base);
    fb_base = base;
    vsync = 1'b1;
    step(1);
    vsync = 1'b0;
  endtask

  // Memory model: acks 2 cycles after a request, returns data = address
  initial begin
    logic [ADDR_W-1:0] a;
    logic got;
    mem.mem_ack = 1'b0;
    mem.mem_rvalid = 1'b0;
    mem.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && mem.mem_req) begin
        a = mem.mem_addr;
        got = 1'b0;
        while (!got) begin
          @(posedge clk); #1;
          if (!rst_n || !mem.mem_req) break;
          if (n_acked < ack_budget) got = 1'b1;
        end
        if (got) begin
          req_log.push_back(32'(a));
          n_acked++;
          beat_idx = 0;
          mem.mem_ack = 1'b1;
          @(posedge clk); #1;
          mem.mem_ack = 1'b0;
          for (int i = 0; i < int'(BURST); i++) begin
            for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
            if (!rst_n) break;
            mem.mem_rvalid = 1'b1;
            mem.mem_rdata  = 32'(a) + 32'(i);
            @(posedge clk); #1;
            mem.mem_rvalid = 1'b0;
            beat_idx++;
            if (!rst_n) break;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic saw;
    int base;

    // Reset values, asynchronously
    #1;
    check("rst_viddata", viddata, 32'd0);
    check("rst_mem_req", 32'(mem.mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem.mem_addr), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    step(2);
    rst_n = 1'b1;

    // No vsync edge: nothing fetched
    saw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (mem.mem_req !== 1'b0 || viddata !== 32'd0 || underflow !== 1'b0) saw = 1'b1;
    end
    check("idle_no_activity", 32'(saw), 32'd0);

    // Frame at 0x100 fills FIFO with exactly four bursts
    vs_pulse(24'h100);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h100 + 32'(i));
    step(100);
    check("f1_req_count", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check("f1_req_addr", (req_log.size() > i) ? req_log[i] : 32'hFFFF_FFFF, 32'h100 + 32'(4 * i));
    check("f1_head", viddata, 32'h100);
    check("f1_no_5th_req", 32'(mem.mem_req), 32'd0);

    // Drain the frame with spaced pops
    for (int i = 0; i < 16; i++) pop("f1_pop");
    check("f1_empty", viddata, 32'd0);
    check("f1_underflow", 32'(underflow), 32'd0);
    step(20);
    check("f1_no_refetch", 32'(req_log.size()), 32'd4);
    check("f1_mem_req_low", 32'(mem.mem_req), 32'd0);

    // Push and pop in the same cycle at count=8
    ack_budget = n_acked + 2;
    gap = 0;
    vs_pulse(24'h300);
    for (int i = 0; i < 12; i++) exp_q.push_back(32'h300 + 32'(i));
    step(60);
    check("ss_head", viddata, 32'h300);
    check("ss_req_pending", 32'(mem.mem_req), 32'd1);
    check("ss_req_addr", 32'(mem.mem_addr), 32'h308);
    ack_budget = ack_budget + 1;
    saw = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (mem.mem_rvalid === 1'b1) begin saw = 1'b1; break; end
    end
    check("ss_beat_seen", 32'(saw), 32'd1);
    pop("ss_pop_with_push");
    step(10);
    for (int i = 0; i < 11; i++) pop("ss_pop");
    check("ss_empty", viddata, 32'd0);

    // vsync mid-burst with gapped beats: remaining beats drained
    gap = 3;
    base = req_log.size();
    ack_budget = 100000;
    saw = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (req_log.size() == base + 1 && beat_idx == 2) begin saw = 1'b1; break; end
    end
    check("dr_mid_burst_reached", 32'(saw), 32'd1);
    exp_q.delete();
    vs_pulse(24'h200);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h200 + 32'(i));
    step(150);
    check("dr_next_req_addr", (req_log.size() > base + 1) ? req_log[base + 1] : 32'hFFFF_FFFF, 32'h200);
    check("dr_req_count", 32'(req_log.size()), 32'(base + 5));
    check("dr_head", viddata, 32'h200);

    // Underflow: sticky until the next vsync edge
    for (int i = 0; i < 16; i++) pop("uf_pop");
    check("uf_empty", viddata, 32'd0);
    check("uf_clear_before", 32'(underflow), 32'd0);
    vid_req = 1'b1;
    step(1);
    vid_req = 1'b0;
    check("uf_set", 32'(underflow), 32'd1);
    check("uf_viddata", viddata, 32'd0);
    step(5);
    check("uf_sticky", 32'(underflow), 32'd1);
    base = req_log.size();
    vs_pulse(24'h400);
    check("uf_cleared_by_vsync", 32'(underflow), 32'd0);
    vid_req = 1'b1;
    step(1);
    vid_req = 1'b0;
    check("uf_set_again", 32'(underflow), 32'd1);

    // Asynchronous reset in the middle of a burst
    saw = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (req_log.size() == base + 1 && beat_idx == 2) begin saw = 1'b1; break; end
    end
    check("ar_mid_burst_reached", 32'(saw), 32'd1);
    check("ar_head_before", viddata, 32'h400);
    check("ar_addr_before", 32'(mem.mem_addr), 32'h400);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_viddata", viddata, 32'd0);
    check("ar_mem_req", 32'(mem.mem_req), 32'd0);
    check("ar_mem_addr", 32'(mem.mem_addr), 32'd0);
    check("ar_underflow", 32'(underflow), 32'd0);
    step(30);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (mem.mem_req !== 1'b0) saw = 1'b1;
    end
    check("ar_disarmed", 32'(saw), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
